// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bus: next-PC controls in from decode/execute, PC and commit strobe out.
interface fetch_pc_unit_if #(
   parameter int unsigned IM_AW = 4
);
   logic [1:0]       npc_op;
   logic             br_taken;
   logic [31:0]      imm;
   logic [31:0]      rs1;
   logic [31:0]      pc;
   logic [IM_AW-1:0] im_addr;
   logic [31:0]      pc_plus4;
   logic             commit;

   modport master (
      output npc_op, br_taken, imm, rs1,
      input  pc, im_addr, pc_plus4, commit
   );

   modport slave (
      input  npc_op, br_taken, imm, rs1,
      output pc, im_addr, pc_plus4, commit
   );
endinterface

// File: rtl/fetch_pc_unit.sv
// PC register with next-PC select, run/step FSM, debounced step button and commit counter.
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned IM_CODE_NUM = 12,
   parameter int unsigned IM_AW       = 4,
   parameter int unsigned DB_CYCLES   = 1_000_000,
   parameter bit          WRAP        = 1'b1
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  tick_i,
   input  logic                  run_i,
   input  logic                  step_btn_i,
   fetch_pc_unit_if.slave        bus_io,
   output logic [1:0]            state_o,
   output logic                  err_o,
   output logic [15:0]           icount_o
);

   localparam int unsigned    DbW    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [DbW-1:0] DbLast = DbW'(DB_CYCLES - 1);
   localparam logic [31:0]    PcEnd  = RESET_PC + 32'(4 * IM_CODE_NUM);

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StRun  = 2'b01,
      StStep = 2'b10,
      StHalt = 2'b11
   } state_e;

   state_e         state_q;
   logic [31:0]    pc_q;
   logic           err_q;
   logic [15:0]    icount_q;
   logic [1:0]     sync_q;
   logic [DbW-1:0] db_cnt_q;
   logic           db_lvl_q;
   logic           step_req_q;

   logic [31:0]    pc_plus4;
   logic [31:0]    pc_d;
   logic           advance;
   logic           misaligned;
   logic           out_of_range;
   logic           db_accept;

   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      pc_d = pc_plus4;
      case (bus_io.npc_op)
         2'b00:   pc_d = pc_plus4;
         2'b01:   pc_d = bus_io.br_taken ? (pc_q + bus_io.imm) : pc_plus4;
         2'b10:   pc_d = pc_q + bus_io.imm;
         default: pc_d = (bus_io.rs1 + bus_io.imm) & ~32'd1;
      endcase
   end

   assign misaligned   = |pc_d[1:0];
   assign out_of_range = (pc_d >= PcEnd) || (pc_d < RESET_PC);
   assign advance      = ((state_q == StRun) && tick_i) || ((state_q == StStep) && step_req_q);

   // A level is taken only after DB_CYCLES consecutive samples differing from the current one.
   assign db_accept = (sync_q[1] != db_lvl_q) && (db_cnt_q == DbLast);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_q     <= 2'b00;
         db_cnt_q   <= '0;
         db_lvl_q   <= 1'b0;
         step_req_q <= 1'b0;
      end else begin
         sync_q     <= {sync_q[0], step_btn_i};
         step_req_q <= db_accept & sync_q[1];
         if (sync_q[1] == db_lvl_q) begin
            db_cnt_q <= '0;
         end else if (db_accept) begin
            db_lvl_q <= sync_q[1];
            db_cnt_q <= '0;
         end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= StIdle;
         pc_q     <= RESET_PC;
         err_q    <= 1'b0;
         icount_q <= 16'h0000;
      end else begin
         if (advance && (icount_q != 16'hFFFF)) icount_q <= icount_q + 16'd1;
         case (state_q)
            StIdle: state_q <= run_i ? StRun : StStep;
            StRun, StStep: begin
               if (advance && misaligned) begin
                  err_q   <= 1'b1;
                  state_q <= StHalt;
               end else if (advance && out_of_range && !WRAP) begin
                  state_q <= StHalt;
               end else begin
                  if (advance) pc_q <= out_of_range ? RESET_PC : pc_d;
                  state_q <= run_i ? StRun : StStep;
               end
            end
            default: state_q <= StHalt;
         endcase
      end
   end

   assign bus_io.pc       = pc_q;
   assign bus_io.im_addr  = pc_q[IM_AW+1:2];
   assign bus_io.pc_plus4 = pc_plus4;
   assign bus_io.commit   = advance;
   assign state_o         = state_q;
   assign err_o           = err_q;
   assign icount_o        = icount_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Runs a wrapping and a halting instance side by side against a small PC model.
module tb_fetch_pc_unit;

   localparam logic [31:0] PcEnd = 32'd48;

   typedef struct packed {
      logic [31:0] pc;
      logic [15:0] cnt;
      logic        err;
      logic        halt;
   } mstate_t;

   typedef struct packed {
      mstate_t w;
      mstate_t h;
   } exp_t;

   logic        clk;
   logic        rstn;
   logic        tick;
   logic        run;
   logic        btn;
   logic [1:0]  state_w, state_h;
   logic        err_w, err_h;
   logic [15:0] icount_w, icount_h;

   fetch_pc_unit_if #(.IM_AW(4)) bus_w ();
   fetch_pc_unit_if #(.IM_AW(4)) bus_h ();

   assign bus_h.npc_op   = bus_w.npc_op;
   assign bus_h.br_taken = bus_w.br_taken;
   assign bus_h.imm      = bus_w.imm;
   assign bus_h.rs1      = bus_w.rs1;

   fetch_pc_unit #(.DB_CYCLES(4), .WRAP(1'b1)) u_dut_w (
      .clk        (clk),
      .rstn       (rstn),
      .tick_i     (tick),
      .run_i      (run),
      .step_btn_i (btn),
      .bus_io     (bus_w),
      .state_o    (state_w),
      .err_o      (err_w),
      .icount_o   (icount_w)
   );

   fetch_pc_unit #(.DB_CYCLES(4), .WRAP(1'b0)) u_dut_h (
      .clk        (clk),
      .rstn       (rstn),
      .tick_i     (tick),
      .run_i      (run),
      .step_btn_i (btn),
      .bus_io     (bus_h),
      .state_o    (state_h),
      .err_o      (err_h),
      .icount_o   (icount_h)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int      n_cmp = 0;
   int      n_bad = 0;
   bit      stepping;
   mstate_t m_w, m_h;
   exp_t    sb_q[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic mstate_t model_adv(input mstate_t s, input bit wrap, input logic [1:0] op,
                                         input logic tk, input logic [31:0] imm,
                                         input logic [31:0] rs1);
      mstate_t     r;
      logic [31:0] t;
      r = s;
      if (s.halt) return s;
      case (op)
         2'b00:   t = s.pc + 32'd4;
         2'b01:   t = tk ? s.pc + imm : s.pc + 32'd4;
         2'b10:   t = s.pc + imm;
         default: t = (rs1 + imm) & 32'hFFFF_FFFE;
      endcase
      if (r.cnt != 16'hFFFF) r.cnt = r.cnt + 16'd1;
      if (t[1:0] != 2'b00) begin
         r.err  = 1'b1;
         r.halt = 1'b1;
      end else if (t >= PcEnd) begin
         if (wrap) r.pc = 32'd0;
         else      r.halt = 1'b1;
      end else begin
         r.pc = t;
      end
      return r;
   endfunction

   function automatic logic [1:0] exp_state(input mstate_t s);
      if (s.halt) return 2'b11;
      return stepping ? 2'b10 : 2'b01;
   endfunction

   task automatic compare_out();
      exp_t e;
      if (sb_q.size() == 0) begin
         check_eq("sb_underflow", 32'd1, 32'd0);
         return;
      end
      e = sb_q.pop_front();
      check_eq("pc_w",     bus_w.pc,         e.w.pc);
      check_eq("icount_w", icount_w,         e.w.cnt);
      check_eq("err_w",    err_w,            e.w.err);
      check_eq("state_w",  state_w,          exp_state(e.w));
      check_eq("imaddr_w", bus_w.im_addr,    e.w.pc[5:2]);
      check_eq("plus4_w",  bus_w.pc_plus4,   e.w.pc + 32'd4);
      check_eq("pc_h",     bus_h.pc,         e.h.pc);
      check_eq("icount_h", icount_h,         e.h.cnt);
      check_eq("err_h",    err_h,            e.h.err);
      check_eq("state_h",  state_h,          exp_state(e.h));
   endtask

   task automatic do_reset(input logic run_mode);
      rstn = 1'b0;
      tick = 1'b0;
      btn  = 1'b0;
      run  = run_mode;
      bus_w.npc_op   = 2'b00;
      bus_w.br_taken = 1'b0;
      bus_w.imm      = 32'd0;
      bus_w.rs1      = 32'd0;
      m_w = '0;
      m_h = '0;
      stepping = !run_mode;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_pc",     bus_w.pc, 32'd0);
      check_eq("rst_state",  state_w,  2'b00);
      check_eq("rst_commit", bus_w.commit, 1'b0);
      check_eq("rst_err",    err_w,    1'b0);
      check_eq("rst_icount", icount_w, 16'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      check_eq("exit_idle", state_w, run_mode ? 2'b01 : 2'b10);
   endtask

   task automatic do_tick(input logic [1:0] op, input logic tk, input logic [31:0] imm,
                          input logic [31:0] rs1);
      exp_t e;
      @(negedge clk);
      bus_w.npc_op   = op;
      bus_w.br_taken = tk;
      bus_w.imm      = imm;
      bus_w.rs1      = rs1;
      tick           = 1'b1;
      e.w = stepping ? m_w : model_adv(m_w, 1'b1, op, tk, imm, rs1);
      e.h = stepping ? m_h : model_adv(m_h, 1'b0, op, tk, imm, rs1);
      #1;
      check_eq("commit_w", bus_w.commit, !stepping && !m_w.halt);
      check_eq("commit_h", bus_h.commit, !stepping && !m_h.halt);
      m_w = e.w;
      m_h = e.h;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      tick = 1'b0;
      compare_out();
   endtask

   initial begin
      int   ncommit;
      exp_t e;

      // Free-run: wrap instance returns to 0 after 44, halting instance stops at 44.
      do_reset(1'b1);
      for (int i = 0; i < 13; i++) do_tick(2'b00, 1'b0, 32'd0, 32'd0);

      // Branch, jal, jalr, then a misaligned jal that halts.
      do_reset(1'b1);
      repeat (2) do_tick(2'b00, 1'b0, 32'd0, 32'd0);
      do_tick(2'b01, 1'b1, 32'hFFFF_FFF8, 32'd0);
      repeat (2) do_tick(2'b00, 1'b0, 32'd0, 32'd0);
      do_tick(2'b01, 1'b0, 32'hFFFF_FFF8, 32'd0);
      do_tick(2'b11, 1'b0, 32'd4, 32'h11);
      do_tick(2'b10, 1'b0, 32'd2, 32'd0);
      repeat (2) do_tick(2'b00, 1'b0, 32'd0, 32'd0);

      // Single-step: ticks ignored, bounce rejected, one clean press commits once.
      do_reset(1'b0);
      repeat (2) do_tick(2'b00, 1'b0, 32'd0, 32'd0);
      ncommit = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         btn = ~btn;
         if (bus_w.commit) ncommit++;
      end
      repeat (2) begin
         @(negedge clk);
         btn = 1'b0;
         if (bus_w.commit) ncommit++;
      end
      e.w = model_adv(m_w, 1'b1, 2'b00, 1'b0, 32'd0, 32'd0);
      e.h = model_adv(m_h, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
      m_w = e.w;
      m_h = e.h;
      sb_q.push_back(e);
      @(negedge clk);
      btn = 1'b1;
      for (int i = 0; i < 35; i++) begin
         @(negedge clk);
         if (i == 20) btn = 1'b0;
         if (bus_w.commit) ncommit++;
      end
      check_eq("step_commits", ncommit, 32'd1);
      compare_out();
      run = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_eq("step_to_run", state_w, 2'b01);

      // Asynchronous reset in mid-run.
      do_reset(1'b1);
      repeat (3) do_tick(2'b00, 1'b0, 32'd0, 32'd0);
      @(posedge clk);
      #3;
      rstn = 1'b0;
      #1;
      check_eq("async_pc",     bus_w.pc, 32'd0);
      check_eq("async_icount", icount_w, 16'd0);
      check_eq("async_state",  state_w,  2'b00);
      check_eq("sb_empty",     sb_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset and on program wrap.
REQ-002 The block SHALL have parameter IM_CODE_NUM, default 12, meaning the number of valid instruction words in instruction memory.
REQ-003 The block SHALL have parameter IM_AW, default 4, meaning the instruction-memory word-address width.
REQ-004 The block SHALL have parameter DB_CYCLES, default 1_000_000, meaning the number of stable clk cycles required to accept a button level.
REQ-005 The block SHALL have parameter WRAP, default 1, where 1 means restart at RESET_PC after the last instruction and 0 means halt.
REQ-006 clk  input  1  system clock; all state changes on its rising edge.
REQ-007 rstn  input  1  reset, asynchronous, active-low.
REQ-008 tick_i  input  1  one-clk-wide CPU-rate enable pulse from the clock divider.
REQ-009 run_i  input  1  mode select: 1 = free-run on tick_i, 0 = single-step on button.
REQ-010 step_btn_i  input  1  raw, asynchronous, bouncing step pushbutton.
REQ-011 npc_op_i  input  2  next-PC select: 00 sequential, 01 conditional branch, 10 jal, 11 jalr.
REQ-012 br_taken_i  input  1  branch condition from the ALU compare; used only when npc_op_i=01.
REQ-013 imm_i  input  32  sign-extended immediate from the immediate extender.
REQ-014 rs1_i  input  32  register-file read port 1 value, used for jalr.
REQ-015 pc_o  output  32  current PC register.
REQ-016 im_addr_o  output  IM_AW  instruction-memory word address, equal to pc_o[IM_AW+1:2].
REQ-017 pc_plus4_o  output  32  pc_o+4, the link value for the register-file write-data mux.
REQ-018 commit_o  output  1  high in the cycle an advance is accepted; qualifies register-file and data-memory writes at the same edge.
REQ-019 state_o  output  2  FSM state encoding: 00 IDLE, 01 RUN, 10 STEP, 11 HALT.
REQ-020 err_o  output  1  sticky misaligned-target error flag.
REQ-021 icount_o  output  16  count of committed instructions.

Function
REQ-022 The block SHALL pass step_btn_i through a 2-FF synchronizer, then a debounce counter that accepts a new level only after DB_CYCLES consecutive equal samples; a rising edge of the debounced level SHALL produce a registered one-cycle step_req.
REQ-023 The FSM SHALL leave IDLE one cycle after reset release, going to RUN if run_i=1 and to STEP otherwise.
REQ-024 From RUN the FSM SHALL go to STEP when run_i=0, and from STEP to RUN when run_i=1; each mode change SHALL take effect on the next cycle.
REQ-025 HALT SHALL be exited only by reset.
REQ-026 An advance SHALL be accepted when the state is RUN and tick_i=1, or when the state is STEP and step_req=1; tick_i SHALL be ignored in STEP and step_req SHALL be ignored in RUN.
REQ-027 commit_o SHALL equal the advance condition and SHALL never be high in IDLE or HALT.
REQ-028 The next PC SHALL be: sequential = pc+4; branch = pc+imm_i if br_taken_i, else pc+4; jal = pc+imm_i; jalr = (rs1_i+imm_i) with bit 0 cleared.
REQ-029 All next-PC adds SHALL be 32-bit, modulo 2^32.
REQ-030 If the next PC has bits [1:0] nonzero, the PC SHALL hold, err_o SHALL set, the state SHALL go to HALT, and commit_o SHALL still pulse for that instruction.
REQ-031 If the aligned next PC is >= RESET_PC+4*IM_CODE_NUM or < RESET_PC, the PC SHALL load RESET_PC when WRAP=1; when WRAP=0 the PC SHALL hold and the state SHALL go to HALT.
REQ-032 icount_o SHALL increment by 1 on every commit and SHALL saturate at 16'hFFFF.
REQ-033 The PC SHALL change only on an accepted advance.

Reset
REQ-034 While rstn=0: pc_o=RESET_PC, state_o=00, commit_o=0, err_o=0, icount_o=0, step_req=0, debounce counter=0, debounced level=0.
REQ-035 Reset assertion in mid-operation SHALL abort immediately, with no partial PC update; the synchronizer flops SHALL reset to 0.

Verification
REQ-036 Free-run: WRAP=1, run_i=1, sequential ops, 13 ticks -> pc_o steps 0,4,...,44, then returns to 0; icount_o=13.
REQ-037 Branch/jal/jalr: pc=8, imm=-8, taken -> pc=0; not taken -> pc=12; jalr with rs1=0x11, imm=4 -> pc=0x14.
REQ-038 Step mode: run_i=0, 5-cycle bounce then a stable press of DB_CYCLES (set to 4) -> exactly one commit and pc +4; tick_i pulses cause no change.
REQ-039 Misalign: jal with imm=2 -> err_o=1, state_o=11, pc held, one commit; further ticks -> no change.
REQ-040 WRAP=0 at the last instruction (pc=44) plus a tick -> state_o=11, pc_o=44; assert rstn mid-run -> pc_o=0 and icount_o=0 asynchronously.
